instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Upstream neighbour of the CPU top-level: owns the program store and program counter, and drives the 20-bit `instruction` input of the CPU core.
- Program is loaded through a write port while the block is idle or halted.
- On `start`, the block issues one instruction per cycle with a valid flag, and supports stall, jump (with flush) and a halt opcode.
- Counts issued instructions for debug.

Parameters:
- INSTR_WIDTH, 20, instruction width; must match the CPU core.
- PC_BITS, 5, program-counter width; the store holds 2^PC_BITS words (32).
- HALT_OP, 4'hF, value of instruction[INSTR_WIDTH-1:INSTR_WIDTH-4] that marks a halt.
- CNT_WIDTH, 8, width of the issue counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- load_en  in  1  program-store write enable.
- load_addr  in  PC_BITS  program-store write address.
- load_data  in  INSTR_WIDTH  program-store write data.
- start  in  1  begin execution at address 0.
- stall  in  1  core back-pressure; freeze issue.
- jump_en  in  1  redirect PC.
- jump_addr  in  PC_BITS  redirect target.
- instruction  out  INSTR_WIDTH  registered instruction to the core.
- instr_valid  out  1  instruction holds a live instruction.
- pc  out  PC_BITS  address of the next word to fetch.
- halted  out  1  halt opcode reached.
- busy  out  1  state is RUN.
- issue_cnt  out  CNT_WIDTH  instructions issued since the last start; saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - pc=0, instruction=0, instr_valid=0, halted=0, busy=0, issue_cnt=0.
  - Program store is NOT reset; its contents are retained.
  - Reset mid-RUN aborts immediately; the first edge after release sees IDLE.
- Program store:
  - 2^PC_BITS x INSTR_WIDTH array.
  - Written synchronously when load_en=1 and state is IDLE or HALT.
  - load_en is ignored in RUN.
  - Reads are combinational from pc into the instruction register.
- States: IDLE, RUN, HALT. busy=1 only in RUN.
- IDLE:
  - Outputs are held at their reset values.
  - start=1 -> pc<=0, issue_cnt<=0, state<=RUN.
  - No instruction is issued on the start edge.
  - start together with load_en: the write lands on the same edge, so the first fetch sees the new word.
- RUN, priority stall > jump > halt > normal, evaluated per edge:
  - stall=1: pc, instruction, instr_valid and issue_cnt all hold. jump_en is ignored while stalled; the requester keeps it asserted.
  - jump_en=1 (stall=0): pc<=jump_addr, instruction<=0, instr_valid<=0. This is a one-cycle flush bubble. issue_cnt holds.
  - Halt opcode (stall=0, jump_en=0, and the top 4 bits of mem[pc] equal HALT_OP): instruction<=0, instr_valid<=0, halted<=1, state<=HALT. pc holds at the halt address. The halt word is never issued.
  - Normal: instruction<=mem[pc], instr_valid<=1, pc<=pc+1 modulo 2^PC_BITS (31 wraps to 0), issue_cnt<=issue_cnt+1, saturating at 2^CNT_WIDTH-1.
- start in RUN is ignored.
- Latency: the first valid instruction appears one edge after the start edge, then one instruction per unstalled cycle.
- HALT:
  - instruction=0, instr_valid=0, halted=1; pc and issue_cnt are frozen.
  - Loads are allowed.
  - start=1 -> halted<=0, pc<=0, issue_cnt<=0, state<=RUN.
- A jump whose target holds the halt opcode halts on the following unstalled edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Load and run:
  - Stimulus: load words 0..3 = 20'h01234, 20'h15678, 20'h29ABC, 20'hF0000; pulse start.
  - Required: cycles 1-3 show instruction 01234, 15678, 29ABC with instr_valid=1. The next edge gives instr_valid=0, halted=1, pc=3, issue_cnt=3, busy=0.
- Stall:
  - Stimulus: during the run, hold stall=1 for 3 cycles after 20'h15678 is issued.
  - Required: instruction stays 15678 with valid=1, pc=2 and issue_cnt=2 frozen. Issue resumes with 29ABC on the first unstalled edge.
- Jump flush:
  - Stimulus: while pc=2, assert jump_en with jump_addr=0.
  - Required: one bubble (valid=0, instruction=0), then 01234, 15678 reissue. jump_en together with stall=1 has no effect until stall=0.
- Wrap and saturation:
  - Stimulus: fill all 32 words with 20'h00001 (no halt); run 300 cycles.
  - Required: pc wraps 31->0, valid stays 1, issue_cnt stops at 255.
- Load guard and restart:
  - Stimulus: load_en in RUN targeting addr 0 with 20'hAAAAA.
  - Required: the store is unchanged. After halt, a load is accepted; start restarts at pc=0 and issues the new word first.
- Async reset mid-run:
  - Stimulus: drop rst between clock edges during issue.
  - Required: outputs clear immediately. After release plus start, the original program reissues from address 0, because memory is retained.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Program store and program counter feeding the CPU core.
//               The store is written through a load port while the block is
//               idle or halted. After start, one instruction per cycle is
//               issued with a valid flag. The block supports core stall,
//               jump with a one-cycle flush bubble, and a halt opcode.
//               A saturating counter tracks instructions issued since start.
// Ports       : clk, rst (async, active-low)
//               load_en/load_addr/load_data - program-store write port
//               start, stall, jump_en/jump_addr - control inputs
//               instruction/instr_valid     - registered issue to the core
//               pc, halted, busy, issue_cnt - status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int         INSTR_WIDTH = 20,
  parameter int         PC_BITS     = 5,
  parameter logic [3:0] HALT_OP     = 4'hF,
  parameter int         CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [PC_BITS-1:0]     jump_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   issue_cnt
);

  localparam int                 c_DEPTH   = 1 << PC_BITS;
  localparam logic [PC_BITS-1:0] c_PC_ONE  = {{(PC_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state;
  logic [INSTR_WIDTH-1:0] r_mem [c_DEPTH];
  logic [PC_BITS-1:0]     r_pc,     w_pc;
  logic [INSTR_WIDTH-1:0] r_instr,  w_instr;
  logic                   r_valid,  w_valid;
  logic                   r_halted, w_halted;
  logic                   r_busy,   w_busy;
  logic [CNT_WIDTH-1:0]   r_cnt,    w_cnt;

  logic [INSTR_WIDTH-1:0] w_fetch;
  logic                   w_is_halt;
  logic                   w_load_ok;

  // Combinational read of the word at the current pc; it only reaches the
  // outputs through r_instr.
  assign w_fetch   = r_mem[r_pc];
  assign w_is_halt = (w_fetch[INSTR_WIDTH-1 -: 4] == HALT_OP);
  assign w_load_ok = load_en && (r_state != S_RUN);

  // The store has no reset so a program survives an aborted run.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_valid  <= w_valid;
      r_halted <= w_halted;
      r_busy   <= w_busy;
      r_cnt    <= w_cnt;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_valid  = r_valid;
    w_halted = r_halted;
    w_cnt    = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        // The start edge only arms the run; the first fetch happens on the
        // following edge, so a load on the start edge is already visible.
        if (start) begin
          w_pc    = '0;
          w_cnt   = '0;
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (stall) begin
          // Everything holds; a pending jump is retried by the requester.
        end else if (jump_en) begin
          w_pc    = jump_addr;
          w_instr = '0;
          w_valid = 1'b0;
        end else if (w_is_halt) begin
          // pc stays on the halt word, which is never issued.
          w_instr  = '0;
          w_valid  = 1'b0;
          w_halted = 1'b1;
          w_state  = S_HALT;
        end else begin
          w_instr = w_fetch;
          w_valid = 1'b1;
          w_pc    = r_pc + c_PC_ONE;
          if (r_cnt != c_CNT_MAX) begin
            w_cnt = r_cnt + c_CNT_ONE;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          w_halted = 1'b0;
          w_pc     = '0;
          w_cnt    = '0;
          w_state  = S_RUN;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    // busy is registered from the next state so it stays a flop output.
    w_busy = (w_state == S_RUN);
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign busy        = r_busy;
  assign issue_cnt   = r_cnt;

endmodule
`default_nettype wire
